// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// tick-source encodings used on unit_sel.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] UNIT_USEC = 2'd0;
    localparam logic [1:0] UNIT_MSEC = 2'd1;
    localparam logic [1:0] UNIT_SEC  = 2'd2;
    localparam logic [1:0] UNIT_CLK  = 2'd3;

endpackage

// File: rtl/countdown_timer.sv
// Countdown timer: counts selected timebase ticks down from a loaded value,
// one-shot or auto-reloading, with a saturating expiry counter.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   usec_pulse/msec_pulse/sec_pulse one-cycle timebase ticks
//   unit_sel                        tick source (usec, msec, sec, every clk)
//   load_val, periodic              sampled on start
//   start, stop                     one-cycle arm/restart and abort requests
//   busy, done                      high in RUN / in DONE
//   expired_pulse                   one-cycle pulse per expiry
//   expire_count                    saturating expiries since last start
//   remaining                       ticks left before expiry
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int EXP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             usec_pulse,
    input  logic             msec_pulse,
    input  logic             sec_pulse,
    input  logic [1:0]       unit_sel,
    input  logic [CNT_W-1:0] load_val,
    input  logic             periodic,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             expired_pulse,
    output logic [EXP_W-1:0] expire_count,
    output logic [CNT_W-1:0] remaining
);

    state_t           r_state;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_remaining;
    logic [EXP_W-1:0] r_exp_cnt;
    logic [1:0]       r_unit;
    logic             r_periodic;
    logic             r_busy;
    logic             r_done;
    logic             r_exp_pulse;

    logic             w_tick;
    logic             w_start_ok;

    // Tick source follows the unit latched at start, not the live input.
    always_comb begin
        w_tick = 1'b0;
        unique case (r_unit)
            UNIT_USEC: w_tick = usec_pulse;
            UNIT_MSEC: w_tick = msec_pulse;
            UNIT_SEC:  w_tick = sec_pulse;
            UNIT_CLK:  w_tick = 1'b1;
            default:   w_tick = 1'b0;
        endcase
    end

    assign w_start_ok = start && (load_val != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_reload    <= '0;
            r_remaining <= '0;
            r_exp_cnt   <= '0;
            r_unit      <= UNIT_USEC;
            r_periodic  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_exp_pulse <= 1'b0;
        end else begin
            r_exp_pulse <= 1'b0;
            if (stop) begin
                // Stop outranks start; in IDLE it is a no-op.
                if (r_state != IDLE) begin
                    r_state     <= IDLE;
                    r_remaining <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            end else if (w_start_ok) begin
                // A coincident tick is dropped on (re)start.
                r_state     <= RUN;
                r_reload    <= load_val;
                r_remaining <= load_val;
                r_unit      <= unit_sel;
                r_periodic  <= periodic;
                r_exp_cnt   <= '0;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
            end else if (r_state == RUN && w_tick) begin
                if (r_remaining == CNT_W'(1)) begin
                    r_exp_pulse <= 1'b1;
                    if (r_exp_cnt != '1) begin
                        r_exp_cnt <= r_exp_cnt + EXP_W'(1);
                    end
                    if (r_periodic) begin
                        // Reload counts this tick as the last of the
                        // previous period, so no tick is lost.
                        r_remaining <= r_reload;
                    end else begin
                        r_remaining <= '0;
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end else begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign expired_pulse = r_exp_pulse;
    assign expire_count  = r_exp_cnt;
    assign remaining     = r_remaining;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: expected expiry cycles are queued
// when a start is driven and matched against observed expired_pulse.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        usec_pulse, msec_pulse, sec_pulse;
    logic [1:0]  unit_sel;
    logic [31:0] load_val;
    logic        periodic, start, stop;

    logic        busy, done, expired_pulse;
    logic [15:0] expire_count;
    logic [31:0] remaining;

    logic        b_busy, b_done, b_expired_pulse;
    logic [1:0]  b_expire_count;
    logic [31:0] b_remaining;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          q[$];
    int          s;

    countdown_timer #(.CNT_W(32), .EXP_W(16)) dut (
        .clk(clk), .rst(rst),
        .usec_pulse(usec_pulse), .msec_pulse(msec_pulse),
        .sec_pulse(sec_pulse), .unit_sel(unit_sel),
        .load_val(load_val), .periodic(periodic),
        .start(start), .stop(stop),
        .busy(busy), .done(done), .expired_pulse(expired_pulse),
        .expire_count(expire_count), .remaining(remaining)
    );

    countdown_timer #(.CNT_W(32), .EXP_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .usec_pulse(usec_pulse), .msec_pulse(msec_pulse),
        .sec_pulse(sec_pulse), .unit_sel(unit_sel),
        .load_val(load_val), .periodic(periodic),
        .start(start), .stop(stop),
        .busy(b_busy), .done(b_done), .expired_pulse(b_expired_pulse),
        .expire_count(b_expire_count), .remaining(b_remaining)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every observed pulse must match the next queued cycle.
    always @(negedge clk) begin
        if (expired_pulse) begin
            if (q.size() == 0) chk("spurious_pulse", cyc, -1);
            else chk("pulse_cycle", cyc, q.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        usec_pulse = 1'b0; msec_pulse = 1'b0; sec_pulse = 1'b0;
        unit_sel = 2'd0; load_val = 32'd0; periodic = 1'b0;
        start = 1'b0; stop = 1'b0;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pulse", expired_pulse, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_cnt", expire_count, 0);
        rst = 1'b0;
        step(1);

        // One-shot, every-clk ticks, load 3
        unit_sel = 2'd3; load_val = 32'd3; periodic = 1'b0; start = 1'b1;
        s = cyc;
        q.push_back(s + 4);
        step(1);
        start = 1'b0;
        chk("os_busy", busy, 1);
        chk("os_rem0", remaining, 3);
        chk("os_done0", done, 0);
        step(2);
        chk("os_rem1", remaining, 1);
        step(1);
        chk("os_done", done, 1);
        chk("os_busy_off", busy, 0);
        chk("os_rem_end", remaining, 0);
        chk("os_cnt", expire_count, 1);
        chk("os_pulse", expired_pulse, 1);
        step(1);
        chk("os_pulse_off", expired_pulse, 0);
        chk("os_done_hold", done, 1);

        // Stop from DONE, then start with load 0 in IDLE
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_done", done, 0);
        chk("stop_cnt_held", expire_count, 1);
        load_val = 32'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("zero_busy", busy, 0);
        chk("zero_done", done, 0);
        step(2);
        chk("zero_busy2", busy, 0);

        // Periodic usec ticks, load 2; unit_sel change mid-run must not matter
        unit_sel = 2'd0; load_val = 32'd2; periodic = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        unit_sel = 2'd3;
        for (int k = 1; k <= 20; k++) begin
            step(4);
            usec_pulse = 1'b1;
            if (k % 2 == 0) q.push_back(cyc + 1);
            step(1);
            usec_pulse = 1'b0;
            chk("per_busy", busy, 1);
        end
        step(2);
        chk("per_cnt", expire_count, 10);
        chk("per_busy_end", busy, 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("per_stop_rem", remaining, 0);

        // Restart coincident with tick, then stop+start together
        unit_sel = 2'd3; load_val = 32'd10; periodic = 1'b0; start = 1'b1;
        s = cyc;
        q.push_back(s + 11);
        step(1);
        start = 1'b0;
        chk("rs_rem10", remaining, 10);
        step(5);
        chk("rs_rem5", remaining, 5);
        load_val = 32'd7; start = 1'b1;
        s = cyc;
        void'(q.pop_back());
        q.push_back(s + 8);
        step(1);
        start = 1'b0;
        chk("rs_rem7", remaining, 7);
        chk("rs_busy", busy, 1);
        step(2);
        chk("rs_rem5b", remaining, 5);
        load_val = 32'd9; start = 1'b1; stop = 1'b1;
        void'(q.pop_back());
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_rem", remaining, 0);
        chk("ss_done", done, 0);
        step(2);
        chk("ss_busy2", busy, 0);

        // Saturation with EXP_W 2: load 1 periodic every clk
        unit_sel = 2'd3; load_val = 32'd1; periodic = 1'b1; start = 1'b1;
        s = cyc;
        for (int k = 2; k <= 11; k++) q.push_back(s + k);
        step(1);
        start = 1'b0;
        step(10);
        chk("sat_cnt_b", b_expire_count, 3);
        chk("sat_pulse_b", b_expired_pulse, 1);
        chk("sat_cnt_a", expire_count, 10);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("sat_stop_pulse", expired_pulse, 0);
        chk("sat_stop_cnt_b", b_expire_count, 3);

        // Reset on the expiring tick
        unit_sel = 2'd3; load_val = 32'd3; periodic = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        chk("rr_rem1", remaining, 1);
        rst = 1'b1;
        step(1);
        chk("rr_pulse", expired_pulse, 0);
        chk("rr_busy", busy, 0);
        chk("rr_done", done, 0);
        chk("rr_rem", remaining, 0);
        chk("rr_cnt", expire_count, 0);
        load_val = 32'd5; start = 1'b1;
        step(1);
        chk("rr_start_ovr", busy, 0);
        rst = 1'b0; start = 1'b0;
        step(4);
        chk("rr_idle", busy, 0);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
